clkdiv_gen: RTL and testbench

CLKDIV_GEN -- requirements
Module: clkdiv_gen

---
 rtl/clkdiv_gen_pkg.sv | 24 ++
 rtl/clkdiv_gen_ch.sv | 97 +++++++++
 rtl/clkdiv_gen.sv | 87 ++++++++
 tb/tb_clkdiv_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_gen_pkg.sv
// ==========================================================================
// clkdiv_gen_pkg : shared constants and channel-state type for clkdiv_gen
// Rev 1.0
// ==========================================================================
`default_nettype none

package clkdiv_gen_pkg;

    localparam int C_CH_IDX_W    = 4;
    localparam int C_CH_MAX      = 16;
    localparam int C_DEFAULT_DIV = 4;
    // Channel state is held at the widest supported divisor width (DIV_W <= 16)
    localparam int C_DIV_MAX_W   = 16;

    typedef struct packed {
        logic [C_DIV_MAX_W-1:0] d;
        logic [C_DIV_MAX_W-1:0] p;
        logic                   pend;
        logic [C_DIV_MAX_W-1:0] cnt;
    } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/clkdiv_gen_ch.sv
// ==========================================================================
// clkdiv_gen_ch : one divider channel (counter, pending divisor, ce/sq decode)
// Rev 1.0  -- sq output present only with CLKDIV_GEN_SQUARE_EN
// ==========================================================================
`default_nettype none

module clkdiv_gen_ch
    import clkdiv_gen_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             calib,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend,
    output logic             ce
`ifdef CLKDIV_GEN_SQUARE_EN
    ,
    output logic             sq
`endif
);

    localparam logic [C_DIV_MAX_W-1:0] C_ONE = C_DIV_MAX_W'(1);

    ch_state_t r_st;
    ch_state_t w_st_nxt;
    logic      r_ce;
    logic      w_ce_nxt;
    logic      w_zero;
    logic      w_wrap;
    logic      w_apply;

    always_comb begin
        w_st_nxt = r_st;
        w_zero   = (r_st.d == '0);
        w_wrap   = !w_zero && (r_st.cnt == (r_st.d - C_ONE));
        w_apply  = r_st.pend && (calib || w_wrap || w_zero);
        w_ce_nxt = w_wrap && !calib;

        if (w_zero || w_wrap || calib) begin
            w_st_nxt.cnt = '0;
        end else begin
            w_st_nxt.cnt = r_st.cnt + C_ONE;
        end

        // An older pending value lands first; a same-cycle write only queues
        if (w_apply) begin
            w_st_nxt.d    = r_st.p;
            w_st_nxt.pend = 1'b0;
            w_st_nxt.cnt  = '0;
        end
        if (wr_en) begin
            w_st_nxt.p    = C_DIV_MAX_W'(wr_div);
            w_st_nxt.pend = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st.d    <= C_DIV_MAX_W'(DEFAULT_DIV);
            r_st.p    <= '0;
            r_st.pend <= 1'b0;
            r_st.cnt  <= '0;
            r_ce      <= 1'b0;
        end else begin
            r_st      <= w_st_nxt;
            r_ce      <= w_ce_nxt;
        end
    end

    assign pend = r_st.pend;
    assign ce   = r_ce;

`ifdef CLKDIV_GEN_SQUARE_EN
    logic                   r_sq;
    logic [C_DIV_MAX_W-1:0] w_half;

    // Decoded from next-state so sq lines up with the registered counter
    assign w_half = (w_st_nxt.d >> 1) + C_DIV_MAX_W'(w_st_nxt.d[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq <= 1'b0;
        end else begin
            r_sq <= (w_st_nxt.d != '0) && (w_st_nxt.cnt < w_half);
        end
    end

    assign sq = r_sq;
`endif

endmodule

`default_nettype wire

// File: rtl/clkdiv_gen.sv
// ==========================================================================
// clkdiv_gen : multi-channel programmable clock-enable divider with calib
// Rev 1.0  -- optional sq_out via macro CLKDIV_GEN_SQUARE_EN
// ==========================================================================
`default_nettype none

module clkdiv_gen
    import clkdiv_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV
) (
    input  logic                  hclkin,
    input  logic                  reset,
    input  logic                  calib,
    input  logic                  wr_valid,
    input  logic [C_CH_IDX_W-1:0] wr_ch,
    input  logic [DIV_W-1:0]      wr_div,
    output logic                  wr_ready,
    output logic                  wr_err,
    output logic [NUM_CH-1:0]     pend,
    output logic [NUM_CH-1:0]     ce_out
`ifdef CLKDIV_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0]     sq_out
`endif
);

    logic                w_in_range;
    logic                w_accept;
    logic [C_CH_MAX-1:0] w_pend_pad;
    logic                r_wr_err;

    // Padding keeps the pend lookup defined for any 4-bit channel index
    assign w_pend_pad = C_CH_MAX'(pend);
    assign w_in_range = ({1'b0, wr_ch} < (C_CH_IDX_W + 1)'(NUM_CH));
    assign wr_ready   = !(w_in_range && w_pend_pad[wr_ch]);
    assign w_accept   = wr_valid && wr_ready;

    always_ff @(posedge hclkin) begin
        if (reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_accept && !w_in_range;
        end
    end

    assign wr_err = r_wr_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic w_wr_en;
        assign w_wr_en = w_accept && w_in_range && (wr_ch == C_CH_IDX_W'(gi));

`ifdef CLKDIV_GEN_SQUARE_EN
        clkdiv_gen_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (hclkin),
            .rst    (reset),
            .calib  (calib),
            .wr_en  (w_wr_en),
            .wr_div (wr_div),
            .pend   (pend[gi]),
            .ce     (ce_out[gi]),
            .sq     (sq_out[gi])
        );
`else
        clkdiv_gen_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (hclkin),
            .rst    (reset),
            .calib  (calib),
            .wr_en  (w_wr_en),
            .wr_div (wr_div),
            .pend   (pend[gi]),
            .ce     (ce_out[gi])
        );
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_gen.sv
// ==========================================================================
// tb_clkdiv_gen : directed self-checking bench for clkdiv_gen
// Rev 1.0  -- sq_out checks only when CLKDIV_GEN_SQUARE_EN is defined
// ==========================================================================
`default_nettype none

module tb_clkdiv_gen;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic              hclkin = 1'b0;
    logic              reset;
    logic              calib;
    logic              wr_valid;
    logic [3:0]        wr_ch;
    logic [DIV_W-1:0]  wr_div;
    logic              wr_ready;
    logic              wr_err;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ce_out;
`ifdef CLKDIV_GEN_SQUARE_EN
    logic [NUM_CH-1:0] sq_out;
`endif

    int tests = 0;
    int fails = 0;

    always #5 hclkin = ~hclkin;

    clkdiv_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .hclkin   (hclkin),
        .reset    (reset),
        .calib    (calib),
        .wr_valid (wr_valid),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .wr_ready (wr_ready),
        .wr_err   (wr_err),
        .pend     (pend),
        .ce_out   (ce_out)
`ifdef CLKDIV_GEN_SQUARE_EN
        ,
        .sq_out   (sq_out)
`endif
    );

    // Leaves the bench at the negedge just before the first edge out of reset
    task automatic do_reset;
        @(negedge hclkin);
        reset = 1'b1; calib = 1'b0; wr_valid = 1'b0; wr_ch = 4'd0; wr_div = '0;
        repeat (2) @(negedge hclkin);
        reset = 1'b0;
    endtask

    task automatic drive_write(input logic [3:0] ch, input logic [DIV_W-1:0] div);
        wr_valid = 1'b1; wr_ch = ch; wr_div = div;
    endtask

    task automatic test_reset;
        @(negedge hclkin);
        reset = 1'b1; calib = 1'b0; wr_valid = 1'b0; wr_ch = 4'd0; wr_div = '0;
        repeat (2) @(negedge hclkin);
        tests++; if (ce_out !== 4'h0) begin fails++; $display("FAIL reset_ce got %b expected 0000", ce_out); end
        tests++; if (pend !== 4'h0) begin fails++; $display("FAIL reset_pend got %b expected 0000", pend); end
        tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL reset_wr_err got %b expected 0", wr_err); end
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %b expected 1", wr_ready); end
`ifdef CLKDIV_GEN_SQUARE_EN
        tests++; if (sq_out !== 4'h0) begin fails++; $display("FAIL reset_sq got %b expected 0000", sq_out); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_defaults;
        logic [3:0] exp;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge hclkin);
            exp = (k % 4 == 0) ? 4'hF : 4'h0;
            tests++;
            if (ce_out !== exp) begin fails++; $display("FAIL defaults_ce k=%0d got %b expected %b", k, ce_out, exp); end
        end
    endtask

    task automatic test_update;
        logic e1, e0, ep;
        do_reset();
        @(negedge hclkin);
        drive_write(4'd1, 8'd6);
        for (int k = 2; k <= 22; k++) begin
            @(negedge hclkin);
            wr_valid = 1'b0;
            e1 = (k == 4) || (k == 10) || (k == 16) || (k == 22);
            e0 = (k % 4 == 0);
            ep = (k < 4);
            tests++; if (ce_out[1] !== e1) begin fails++; $display("FAIL update_ce1 k=%0d got %b expected %b", k, ce_out[1], e1); end
            tests++; if (ce_out[0] !== e0) begin fails++; $display("FAIL update_ce0 k=%0d got %b expected %b", k, ce_out[0], e0); end
            tests++; if (pend[1] !== ep) begin fails++; $display("FAIL update_pend1 k=%0d got %b expected %b", k, pend[1], ep); end
        end
    endtask

    task automatic test_back_to_back;
        logic ec, ep;
        do_reset();
        drive_write(4'd2, 8'd3);
        for (int k = 1; k <= 17; k++) begin
            @(negedge hclkin);
            ec = (k == 4) || (k == 7) || (k == 12) || (k == 17);
            ep = (k <= 3) || (k == 5) || (k == 6);
            if (k <= 4) begin
                tests++;
                if (wr_ready !== (k == 4)) begin fails++; $display("FAIL b2b_wr_ready k=%0d got %b expected %b", k, wr_ready, (k == 4)); end
            end
            tests++; if (pend[2] !== ep) begin fails++; $display("FAIL b2b_pend2 k=%0d got %b expected %b", k, pend[2], ep); end
            tests++; if (ce_out[2] !== ec) begin fails++; $display("FAIL b2b_ce2 k=%0d got %b expected %b", k, ce_out[2], ec); end
            if (k == 1) wr_div = 8'd5;
            if (k == 5) wr_valid = 1'b0;
        end
    endtask

    task automatic test_stop_and_one;
        logic ec, ep;
        do_reset();
        drive_write(4'd0, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge hclkin);
            ec = (k == 4) || (k >= 8);
            ep = (k < 4) || (k == 6);
            tests++; if (ce_out[0] !== ec) begin fails++; $display("FAIL stop_ce0 k=%0d got %b expected %b", k, ce_out[0], ec); end
            tests++; if (pend[0] !== ep) begin fails++; $display("FAIL stop_pend0 k=%0d got %b expected %b", k, pend[0], ep); end
            if (k == 1) wr_valid = 1'b0;
            if (k == 5) drive_write(4'd0, 8'd1);
            if (k == 6) wr_valid = 1'b0;
        end
    endtask

    task automatic test_calib;
        logic [3:0] exp;
        do_reset();
        drive_write(4'd0, 8'd3);
        for (int k = 1; k <= 20; k++) begin
            @(negedge hclkin);
            if (k == 4) begin
                tests++; if (pend !== 4'h0) begin fails++; $display("FAIL calib_pend_applied got %b expected 0000", pend); end
            end
            if (k >= 7 && k <= 16) begin
                exp[0] = (k > 7) && ((k - 7) % 3 == 0);
                exp[1] = (k > 7) && ((k - 7) % 5 == 0);
                exp[2] = (k > 7) && ((k - 7) % 7 == 0);
                exp[3] = (k > 7) && ((k - 7) % 4 == 0);
                tests++; if (ce_out !== exp) begin fails++; $display("FAIL calib_ce k=%0d got %b expected %b", k, ce_out, exp); end
            end
            if (k == 17) begin
                tests++; if (pend[3] !== 1'b1) begin fails++; $display("FAIL calib_pend3_set got %b expected 1", pend[3]); end
            end
            if (k == 18) begin
                tests++; if (pend[3] !== 1'b0) begin fails++; $display("FAIL calib_pend3_clr got %b expected 0", pend[3]); end
            end
            if (k >= 18) begin
                tests++; if (ce_out[3] !== (k == 20)) begin fails++; $display("FAIL calib_ce3 k=%0d got %b expected %b", k, ce_out[3], (k == 20)); end
            end
            case (k)
                1:  drive_write(4'd1, 8'd5);
                2:  drive_write(4'd2, 8'd7);
                3:  wr_valid = 1'b0;
                6:  calib = 1'b1;
                7:  calib = 1'b0;
                16: drive_write(4'd3, 8'd2);
                17: begin wr_valid = 1'b0; calib = 1'b1; end
                18: calib = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_wr_err;
        logic [3:0] exp;
        do_reset();
        drive_write(4'd9, 8'd7);
        #1;
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL err_wr_ready got %b expected 1", wr_ready); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge hclkin);
            exp = (k % 4 == 0) ? 4'hF : 4'h0;
            tests++; if (wr_err !== (k == 1)) begin fails++; $display("FAIL err_pulse k=%0d got %b expected %b", k, wr_err, (k == 1)); end
            tests++; if (pend !== 4'h0) begin fails++; $display("FAIL err_pend k=%0d got %b expected 0000", k, pend); end
            tests++; if (ce_out !== exp) begin fails++; $display("FAIL err_ce k=%0d got %b expected %b", k, ce_out, exp); end
            if (k == 1) wr_valid = 1'b0;
        end
    endtask

    task automatic test_reset_override;
        logic [3:0] exp;
        do_reset();
        drive_write(4'd1, 8'd6);
        @(negedge hclkin);
        tests++; if (pend[1] !== 1'b1) begin fails++; $display("FAIL ovr_pend_before got %b expected 1", pend[1]); end
        reset = 1'b1; calib = 1'b1; drive_write(4'd2, 8'd9);
        @(negedge hclkin);
        tests++; if (pend !== 4'h0) begin fails++; $display("FAIL ovr_pend got %b expected 0000", pend); end
        tests++; if (ce_out !== 4'h0) begin fails++; $display("FAIL ovr_ce got %b expected 0000", ce_out); end
        reset = 1'b0; calib = 1'b0; wr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge hclkin);
            exp = (k % 4 == 0) ? 4'hF : 4'h0;
            tests++; if (ce_out !== exp) begin fails++; $display("FAIL ovr_ce_after k=%0d got %b expected %b", k, ce_out, exp); end
            tests++; if (pend !== 4'h0) begin fails++; $display("FAIL ovr_pend_after k=%0d got %b expected 0000", k, pend); end
        end
    endtask

`ifdef CLKDIV_GEN_SQUARE_EN
    task automatic test_square;
        logic e0, e1;
        do_reset();
        drive_write(4'd0, 8'd5);
        for (int k = 1; k <= 14; k++) begin
            @(negedge hclkin);
            e0 = (k < 4) ? (k < 2) : (((k - 4) % 5) < 3);
            e1 = ((k % 4) < 2);
            tests++; if (sq_out[0] !== e0) begin fails++; $display("FAIL sq0 k=%0d got %b expected %b", k, sq_out[0], e0); end
            tests++; if (sq_out[1] !== e1) begin fails++; $display("FAIL sq1 k=%0d got %b expected %b", k, sq_out[1], e1); end
            if (k == 1) wr_valid = 1'b0;
        end
    endtask
`endif

    initial begin
        reset = 1'b1; calib = 1'b0; wr_valid = 1'b0; wr_ch = 4'd0; wr_div = '0;
        test_reset();
        test_defaults();
        test_update();
        test_back_to_back();
        test_stop_and_one();
        test_calib();
        test_wr_err();
        test_reset_override();
`ifdef CLKDIV_GEN_SQUARE_EN
        test_square();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
